// File: rtl/seq_rcgn_pkg.sv
// Shared constants for the serial sequence recogniser: the power-up configuration
// (the classic 0110 overlapping detector) and the config-length width helper.
package seq_rcgn_pkg;

  localparam logic [3:0] DEFAULT_PAT = 4'b0110;
  localparam int         DEFAULT_LEN = 4;
  localparam logic       DEFAULT_OVL = 1'b1;

  // Bits needed to hold a length in 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_rcgn_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_rcgn_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_rcgn_param.sv
// Runtime-configurable serial pattern recogniser: compares the last len enabled
// samples of x against pat and pulses out on the edge that samples the final bit.
module seq_rcgn_param
  import seq_rcgn_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(DEFAULT_PAT);
  localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(DEFAULT_LEN);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               load_ok;
  logic               sample;

  // Only the low len bits take part in the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign mask[gi] = (LEN_W'(gi) < len);
  end

  assign hist_next = (hist << 1) | MAX_LEN'(x);
  assign fill_next = (fill == MAX_LEN_L) ? fill : fill + LEN_W'(1);
  assign hit       = (fill_next >= len) && (((hist_next ^ pat) & mask) == '0);
  assign load_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  assign sample    = en && !cfg_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat     <= RST_PAT;
      len     <= RST_LEN;
      ovl     <= DEFAULT_OVL;
      hist    <= '0;
      fill    <= '0;
      out     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      out     <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_load) begin
        // x is dropped on any load edge; a rejected load leaves everything else intact.
        if (load_ok) begin
          pat  <= cfg_pattern;
          len  <= cfg_len;
          ovl  <= cfg_overlap;
          hist <= '0;
          fill <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (en) begin
        hist <= hist_next;
        // Non-overlapping mode forgets consumed bits by emptying the fill count.
        fill <= (hit && !ovl) ? '0 : fill_next;
        out  <= hit;
      end
    end
  end

  seq_rcgn_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cfg_load && load_ok),
    .inc   (sample && hit),
    .cnt   (match_cnt)
  );

endmodule

// File: tb/tb_seq_rcgn_param.sv
// Directed-vector bench for seq_rcgn_param (MAX_LEN=8, CNT_W=2).
module tb_seq_rcgn_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;

  logic               clk;
  logic               reset;
  logic               en;
  logic               x;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  int checks   = 0;
  int failures = 0;

  seq_rcgn_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .x           (x),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic b);
    en = e;
    x  = b;
    @(posedge clk);
    #1;
    $display("txn en=%0b x=%0b out=%0b cnt=%0d err=%0b", e, b, out, match_cnt, cfg_err);
  endtask

  task automatic ld(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    en          = 1'b1;
    x           = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    $display("txn load pat=%b len=%0d ovl=%0b out=%0b cnt=%0d err=%0b", p, l, o, out, match_cnt, cfg_err);
  endtask

  // Feed n bits MSB-first with en=1, checking out after each edge.
  task automatic feed(input logic [15:0] xs, input logic [15:0] exps, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, xs[n-1-i]);
      chk($sformatf("%s_out[%0d]", tag, i + 1), out, exps[n-1-i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] gbits;
    reset       = 1'b1;
    en          = 1'b0;
    x           = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    #1;
    chk("rst_out", out, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_err", cfg_err, 0);
    #12;
    reset = 1'b0;

    // Default 0110 overlapping detector.
    feed(16'b0110110, 16'b0001001, 7, "ovl");
    chk("ovl_cnt", match_cnt, 2);

    // Non-overlapping.
    ld(8'b0000_0110, 4'd4, 1'b0);
    chk("ld_out", out, 0);
    chk("ld_cnt", match_cnt, 0);
    chk("ld_err", cfg_err, 0);
    feed(16'b0110110, 16'b0001000, 7, "novl");
    chk("novl_cnt", match_cnt, 1);

    // Enable gaps with x toggling during the gaps.
    ld(8'b0000_0110, 4'd4, 1'b1);
    chk("gap_ld_cnt", match_cnt, 0);
    gbits = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, gbits[i]);
      chk($sformatf("gap_bit_out[%0d]", 4 - i), out, (i == 0) ? 1 : 0);
      if (i != 0) begin
        step(1'b0, ~gbits[i]);
        chk("gap_idle_out", out, 0);
        step(1'b0, gbits[i]);
        chk("gap_idle_out", out, 0);
      end
    end
    chk("gap_cnt", match_cnt, 1);

    // Illegal load: rejected, nothing cleared, out dropped.
    ld(8'hFF, 4'd9, 1'b0);
    chk("bad_err", cfg_err, 1);
    chk("bad_out", out, 0);
    chk("bad_cnt", match_cnt, 1);
    step(1'b0, 1'b0);
    chk("bad_err_clr", cfg_err, 0);
    feed(16'b0110, 16'b0001, 4, "post_bad");
    chk("post_bad_cnt", match_cnt, 2);

    // len 2 with junk above len: back-to-back 11 matches.
    ld(8'b1010_1011, 4'd2, 1'b1);
    feed(16'b1111, 16'b0111, 4, "len2");
    chk("len2_cnt", match_cnt, 3);

    // Max length all-ones, counter saturation.
    ld(8'hFF, 4'd8, 1'b1);
    chk("max_ld_cnt", match_cnt, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("max_out[%0d]", i), out, (i >= 8) ? 1 : 0);
      chk($sformatf("max_cnt[%0d]", i), match_cnt, (i < 8) ? 0 : ((i - 7 > 3) ? 3 : i - 7));
    end

    // Asynchronous reset while out is high.
    reset = 1'b1;
    #2;
    chk("async_out", out, 0);
    chk("async_cnt", match_cnt, 0);
    #2;
    reset = 1'b0;

    // Defaults restored, then lose partial progress to reset.
    feed(16'b0110, 16'b0001, 4, "rst_dflt");
    chk("rst_dflt_cnt", match_cnt, 1);
    feed(16'b11, 16'b00, 2, "partial");
    reset = 1'b1;
    #2;
    reset = 1'b0;
    feed(16'b00110, 16'b00001, 5, "post_rst");
    chk("post_rst_cnt", match_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
